// File: rtl/esi_cosim_seq_pkg.sv
// Shared types for the cosim reset/run sequencer: FSM state and error codes.
package esi_cosim_seq_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT   = 3'd0,
    ST_WAIT_ACK = 3'd1,
    ST_RUN      = 3'd2,
    ST_DONE     = 3'd3,
    ST_ERROR    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'd0,
    ERR_ACK_TIMEOUT = 2'd1,
    ERR_READY_LOST  = 2'd2
  } err_e;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/esi_cosim_sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over enable.
module esi_cosim_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_enable,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/esi_cosim_reset_sequencer.sv
// Drives the cosim DUT through reset hold, ready handshake and a budgeted run phase.
module esi_cosim_reset_sequencer
  import esi_cosim_seq_pkg::*;
#(
  parameter int RESET_CYCLES = 4,
  parameter int ACK_TIMEOUT  = 256,
  parameter int CYCLE_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reset_req,
  input  logic [CYCLE_W-1:0] cycle_limit,
  input  logic               dut_ready,
  output logic               dut_rst,
  output logic               run,
  output logic               done,
  output logic [1:0]         err,
  output logic [CYCLE_W-1:0] cycles_run,
  output logic [2:0]         state_o
);

  localparam int HOLD_W = cnt_width(RESET_CYCLES);
  localparam int WAIT_W = cnt_width(ACK_TIMEOUT);

  state_e             r_state, w_state_next;
  err_e               r_err, w_err_next;
  logic [CYCLE_W-1:0] r_limit;
  logic               w_run_entry;

  logic [HOLD_W-1:0]  w_hold_cnt;
  logic [WAIT_W-1:0]  w_wait_cnt;
  logic [CYCLE_W-1:0] w_cycles_run;
  logic               w_hold_last, w_wait_last, w_limit_hit;

  esi_cosim_sat_counter #(.W(HOLD_W)) u_hold_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (reset_req || (r_state != ST_ASSERT)),
    .i_enable (r_state == ST_ASSERT),
    .o_count  (w_hold_cnt)
  );

  esi_cosim_sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (reset_req || (r_state != ST_WAIT_ACK)),
    .i_enable (r_state == ST_WAIT_ACK),
    .o_count  (w_wait_cnt)
  );

  // Held at zero through WAIT_ACK so RUN always starts counting from zero.
  esi_cosim_sat_counter #(.W(CYCLE_W)) u_cycles_run (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (reset_req || (r_state == ST_WAIT_ACK)),
    .i_enable (r_state == ST_RUN),
    .o_count  (w_cycles_run)
  );

  assign w_hold_last = (w_hold_cnt == HOLD_W'(RESET_CYCLES - 1));
  assign w_wait_last = (ACK_TIMEOUT != 0) && (w_wait_cnt == WAIT_W'(ACK_TIMEOUT - 1));
  assign w_limit_hit = (r_limit != '0) && ((w_cycles_run + CYCLE_W'(1)) == r_limit);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_err_next   = r_err;
    w_run_entry  = 1'b0;
    if (reset_req) begin
      w_state_next = ST_ASSERT;
      w_err_next   = ERR_NONE;
    end else begin
      case (r_state)
        ST_ASSERT: begin
          if (w_hold_last) w_state_next = ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (dut_ready) begin
            w_state_next = ST_RUN;
            w_run_entry  = 1'b1;
          end else if (w_wait_last) begin
            w_state_next = ST_ERROR;
            w_err_next   = ERR_ACK_TIMEOUT;
          end
        end
        ST_RUN: begin
          if (!dut_ready) begin
            w_state_next = ST_ERROR;
            w_err_next   = ERR_READY_LOST;
          end else if (w_limit_hit) begin
            w_state_next = ST_DONE;
          end
        end
        ST_DONE, ST_ERROR: ;
        default: w_state_next = ST_ASSERT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ASSERT;
      r_err   <= ERR_NONE;
      r_limit <= '0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_err_next;
      if (w_run_entry) r_limit <= cycle_limit;
    end
  end

  assign dut_rst    = (r_state == ST_ASSERT);
  assign run        = (r_state == ST_RUN);
  assign done       = (r_state == ST_DONE);
  assign err        = r_err;
  assign cycles_run = w_cycles_run;
  assign state_o    = r_state;

endmodule

// File: tb/tb_esi_cosim_reset_sequencer.sv
// Directed bench: default-parameter sequencer plus a narrow-counter, short-timeout instance.
module tb_esi_cosim_reset_sequencer;
  import esi_cosim_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, reset_req, dut_ready;
  logic [31:0] cycle_limit;
  logic        dut_rst, run, done;
  logic [1:0]  err;
  logic [31:0] cycles_run;
  logic [2:0]  state_o;

  logic        s_rst, s_reset_req, s_ready;
  logic [3:0]  s_limit;
  logic        s_dut_rst, s_run, s_done;
  logic [1:0]  s_err;
  logic [3:0]  s_cycles;
  logic [2:0]  s_state;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen;

  esi_cosim_reset_sequencer u_dut (
    .clk         (clk),
    .rst         (rst),
    .reset_req   (reset_req),
    .cycle_limit (cycle_limit),
    .dut_ready   (dut_ready),
    .dut_rst     (dut_rst),
    .run         (run),
    .done        (done),
    .err         (err),
    .cycles_run  (cycles_run),
    .state_o     (state_o)
  );

  esi_cosim_reset_sequencer #(.RESET_CYCLES(4), .ACK_TIMEOUT(8), .CYCLE_W(4)) u_small (
    .clk         (clk),
    .rst         (s_rst),
    .reset_req   (s_reset_req),
    .cycle_limit (s_limit),
    .dut_ready   (s_ready),
    .dut_rst     (s_dut_rst),
    .run         (s_run),
    .done        (s_done),
    .err         (s_err),
    .cycles_run  (s_cycles),
    .state_o     (s_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; reset_req = 1'b0; dut_ready = 1'b0; cycle_limit = 32'd10;
    s_rst = 1'b1; s_reset_req = 1'b0; s_ready = 1'b0; s_limit = 4'd0;
    step(2);
    check("rst_state", 32'(state_o), 32'(ST_ASSERT));
    check("rst_dut_rst", 32'(dut_rst), 32'd1);
    check("rst_run", 32'(run), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cycles", cycles_run, 32'd0);

    // Reset hold: dut_rst high for exactly 4 cycles after rst falls.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("hold_dut_rst", 32'(dut_rst), 32'd1);
      step(1);
    end
    check("wait_entry_state", 32'(state_o), 32'(ST_WAIT_ACK));
    check("wait_entry_dut_rst", 32'(dut_rst), 32'd0);
    step(1);
    check("wait_second_cycle", 32'(state_o), 32'(ST_WAIT_ACK));
    dut_ready = 1'b1;
    step(1);

    // Run exactly 10 cycles; a late change of cycle_limit must be ignored.
    for (int i = 0; i < 10; i++) begin
      check("run_high", 32'(run), 32'd1);
      check("run_count", cycles_run, 32'(i));
      if (i == 2) cycle_limit = 32'd3;
      step(1);
    end
    check("done_state", 32'(state_o), 32'(ST_DONE));
    check("done_flag", 32'(done), 32'd1);
    check("done_run_low", 32'(run), 32'd0);
    check("done_cycles", cycles_run, 32'd10);
    check("done_err", 32'(err), 32'd0);
    step(3);
    check("done_sticky", 32'(done), 32'd1);
    check("done_frozen", cycles_run, 32'd10);

    // reset_req from DONE restarts the sequence.
    dut_ready = 1'b0; cycle_limit = 32'd10; reset_req = 1'b1;
    step(1);
    reset_req = 1'b0;
    check("rreq_state", 32'(state_o), 32'(ST_ASSERT));
    check("rreq_done_clr", 32'(done), 32'd0);
    check("rreq_cycles_clr", cycles_run, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("rreq_hold", 32'(dut_rst), 32'd1);
      step(1);
    end
    check("rreq_wait", 32'(state_o), 32'(ST_WAIT_ACK));
    dut_ready = 1'b1;
    step(1);

    // Ready lost at cycles_run=5.
    check("lost_run", 32'(state_o), 32'(ST_RUN));
    step(5);
    check("lost_pre", cycles_run, 32'd5);
    dut_ready = 1'b0;
    step(1);
    check("lost_state", 32'(state_o), 32'(ST_ERROR));
    check("lost_err", 32'(err), 32'd2);
    check("lost_cycles", cycles_run, 32'd6);
    check("lost_run_low", 32'(run), 32'd0);
    check("lost_dut_rst", 32'(dut_rst), 32'd0);
    dut_ready = 1'b1;
    step(2);
    check("lost_err_sticky", 32'(err), 32'd2);
    check("lost_frozen", cycles_run, 32'd6);
    check("lost_state_held", 32'(state_o), 32'(ST_ERROR));
    reset_req = 1'b1;
    step(1);
    reset_req = 1'b0;
    check("err_clr", 32'(err), 32'd0);
    check("err_cycles_clr", cycles_run, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("err_rreq_hold", 32'(dut_rst), 32'd1);
      step(1);
    end
    check("err_rreq_wait", 32'(state_o), 32'(ST_WAIT_ACK));

    // reset_req on the same cycle the limit of 3 is reached.
    cycle_limit = 32'd3;
    step(1);
    check("coll_run", 32'(state_o), 32'(ST_RUN));
    step(2);
    check("coll_pre", cycles_run, 32'd2);
    reset_req = 1'b1;
    step(1);
    reset_req = 1'b0;
    check("coll_state", 32'(state_o), 32'(ST_ASSERT));
    check("coll_done", 32'(done), 32'd0);
    check("coll_cycles", cycles_run, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) done_seen++;
      step(1);
    end
    check("coll_done_never", 32'(done_seen), 32'd0);

    // Unlimited budget for 300 cycles.
    cycle_limit = 32'd0;
    step(1);
    check("unl_run", 32'(state_o), 32'(ST_RUN));
    check("unl_start", cycles_run, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (done) done_seen++;
    end
    check("unl_no_done", 32'(done_seen), 32'd0);
    check("unl_cycles", cycles_run, 32'd300);
    check("unl_still_run", 32'(run), 32'd1);

    // rst mid-RUN returns everything to reset values.
    rst = 1'b1;
    step(1);
    check("mid_rst_state", 32'(state_o), 32'(ST_ASSERT));
    check("mid_rst_dut_rst", 32'(dut_rst), 32'd1);
    check("mid_rst_run", 32'(run), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_cycles", cycles_run, 32'd0);
    rst = 1'b0;

    // Small instance: ack timeout of 8 cycles.
    s_rst = 1'b0;
    step(4);
    check("to_wait", 32'(s_state), 32'(ST_WAIT_ACK));
    for (int i = 0; i < 8; i++) begin
      check("to_waiting", 32'(s_state), 32'(ST_WAIT_ACK));
      check("to_no_run", 32'(s_run), 32'd0);
      step(1);
    end
    check("to_state", 32'(s_state), 32'(ST_ERROR));
    check("to_err", 32'(s_err), 32'd1);
    check("to_dut_rst", 32'(s_dut_rst), 32'd0);
    check("to_run", 32'(s_run), 32'd0);

    // reset_req in ASSERT restarts the hold count.
    s_reset_req = 1'b1;
    step(1);
    s_reset_req = 1'b0;
    check("s_rreq_state", 32'(s_state), 32'(ST_ASSERT));
    check("s_rreq_err", 32'(s_err), 32'd0);
    step(1);
    s_reset_req = 1'b1;
    step(1);
    s_reset_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("restart_hold", 32'(s_dut_rst), 32'd1);
      step(1);
    end
    check("restart_wait", 32'(s_state), 32'(ST_WAIT_ACK));

    // Ready rises on the exact timeout cycle: ready wins.
    step(7);
    check("edge_wait", 32'(s_state), 32'(ST_WAIT_ACK));
    s_ready = 1'b1;
    step(1);
    check("edge_run", 32'(s_state), 32'(ST_RUN));
    check("edge_err", 32'(s_err), 32'd0);

    // 4-bit counter saturates at 15 with an unlimited budget.
    step(15);
    check("sat_15", 32'(s_cycles), 32'd15);
    step(5);
    check("sat_hold", 32'(s_cycles), 32'd15);
    check("sat_run", 32'(s_state), 32'(ST_RUN));
    check("sat_no_done", 32'(s_done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
